alu_pc_dmem: RTL and testbench

Execute/memory slice of the 8-bit single-cycle processor. It holds the program-counter register and a 2-op-select 8-bit ALU with NZCV flags. It also holds a 256×8 data memory addressed by the ALU result. Register file, instruction memory, control decode, PC+1 adder and writeback muxes sit outside. This block receives the next-PC value and the two register operands, and returns PC, ALU result, flags and memory read data.

---
 rtl/alu_pc_dmem_pkg.sv | 14 +
 rtl/alu_pc_dmem_alu_core.sv | 28 ++
 rtl/alu_pc_dmem.sv | 44 ++++
 tb/tb_alu_pc_dmem.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pc_dmem_pkg.sv
// alu_pc_dmem_pkg: shared widths, flag indices and ALU op encoding
package alu_pc_dmem_pkg;
  localparam int DATA_W = 8;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_e;
endpackage

// File: rtl/alu_pc_dmem_alu_core.sv
// alu_core: combinational 8-bit ADD/SUB/AND/OR with NZCV flags
module alu_core
  import alu_pc_dmem_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_e           i_op,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags
);
  logic              w_sub;
  logic              w_arith;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_sum;
  always_comb begin
    w_sub    = i_op == SUB;
    w_arith  = i_op == ADD || w_sub;
    w_b      = w_sub ? ~i_b : i_b;
    w_sum    = {1'b0, i_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_sub};
    o_result = i_op == AND ? i_a & i_b : i_op == OR ? i_a | i_b : w_sum[DATA_W-1:0];
    o_flags         = '0;
    o_flags[FLAG_N] = o_result[DATA_W-1];
    o_flags[FLAG_Z] = o_result == '0;
    o_flags[FLAG_C] = w_arith & w_sum[DATA_W];
    // overflow judged on the adder's operands, so SUB uses the inverted B
    o_flags[FLAG_V] = w_arith & (i_a[DATA_W-1] == w_b[DATA_W-1]) & (o_result[DATA_W-1] != i_a[DATA_W-1]);
  end
endmodule

// File: rtl/alu_pc_dmem.sv
// alu_pc_dmem: PC register, ALU and 256x8 data memory addressed by the ALU result
module alu_pc_dmem
  import alu_pc_dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pc_next,
  output logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [1:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_result,
  output logic [3:0]        alu_flags,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata
);
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_result;
  logic [3:0]        w_flags;
  alu_core u_alu (
    .i_a      (alu_a),
    .i_b      (alu_b),
    .i_op     (alu_op_e'(alu_ctrl)),
    .o_result (w_result),
    .o_flags  (w_flags)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_pc <= pc_next;
      if (mem_we) r_mem[w_result] <= mem_wdata;
    end
  end
  assign pc         = r_pc;
  assign alu_result = w_result;
  assign alu_flags  = w_flags;
  assign mem_rdata  = r_mem[w_result];
endmodule

// File: tb/tb_alu_pc_dmem.sv
// tb_alu_pc_dmem: directed and randomized checks against a behavioural model
module tb_alu_pc_dmem;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] pc_next = 0, pc, alu_a = 0, alu_b = 0, alu_result, mem_wdata = 0, mem_rdata;
  logic [1:0] alu_ctrl = 0;
  logic [3:0] alu_flags;
  logic       mem_we = 0;
  int         pass_cnt = 0, chk_cnt = 0;
  logic [7:0] m_mem [256];
  logic [7:0] m_pc = 0;

  alu_pc_dmem dut (
    .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc(pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic void model_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] r, output logic [3:0] f);
    int ua, ub, sa, sb, u, s;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = 0; v = 0;
    case (op)
      2'd0: begin u = ua + ub; s = sa + sb; c = u > 255; v = s > 127 || s < -128; end
      2'd1: begin u = ua - ub; s = sa - sb; c = ua >= ub; v = s > 127 || s < -128; end
      2'd2: u = ua & ub;
      default: u = ua | ub;
    endcase
    r = u[7:0];
    f = {r[7], r == 8'h00, c, v};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic we, input logic [7:0] wd);
    alu_ctrl = op; alu_a = a; alu_b = b; mem_we = we; mem_wdata = wd;
    #1;
  endtask

  task automatic tick();
    logic [7:0] r;
    logic [3:0] f;
    model_alu(alu_ctrl, alu_a, alu_b, r, f);
    if (!rst_n) begin
      m_pc = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = 0;
    end else begin
      m_pc = pc_next;
      if (mem_we) m_mem[r] = mem_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] addrs [3] = '{8'h00, 8'h7F, 8'hFF};
    rst_n = 0; pc_next = 8'h55;
    drive(2'd0, 8'h12, 8'h00, 1'b1, 8'hAA);
    tick(); tick();
    chk_cnt++;
    if (pc !== 8'h00) $display("FAIL reset_pc got=%h exp=00", pc); else pass_cnt++;
    foreach (addrs[i]) begin
      drive(2'd0, addrs[i], 8'h00, 1'b1, 8'hAA);
      chk_cnt++;
      if (mem_rdata !== 8'h00) $display("FAIL reset_mem[%h] got=%h exp=00", addrs[i], mem_rdata);
      else pass_cnt++;
    end
    rst_n = 1; pc_next = 8'h01;
    drive(2'd0, 8'h00, 8'h00, 1'b0, 8'h00);
    tick();
    chk_cnt++;
    if (pc !== 8'h01) $display("FAIL release_pc got=%h exp=01", pc); else pass_cnt++;
  endtask

  task automatic test_alu_directed();
    logic [7:0] vec [7][5] = '{
      '{8'd0, 8'h7F, 8'h01, 8'h80, 8'b1001},
      '{8'd0, 8'hFF, 8'h01, 8'h00, 8'b0110},
      '{8'd1, 8'h05, 8'h05, 8'h00, 8'b0110},
      '{8'd1, 8'h03, 8'h05, 8'hFE, 8'b1000},
      '{8'd1, 8'h80, 8'h01, 8'h7F, 8'b0011},
      '{8'd2, 8'hF0, 8'h3C, 8'h30, 8'b0000},
      '{8'd3, 8'h00, 8'h00, 8'h00, 8'b0100}
    };
    foreach (vec[i]) begin
      drive(vec[i][0][1:0], vec[i][1], vec[i][2], 1'b0, 8'h00);
      chk_cnt++;
      if (alu_result !== vec[i][3])
        $display("FAIL alu_result[%0d] got=%h exp=%h", i, alu_result, vec[i][3]);
      else pass_cnt++;
      chk_cnt++;
      if (alu_flags !== vec[i][4][3:0])
        $display("FAIL alu_flags[%0d] got=%b exp=%b", i, alu_flags, vec[i][4][3:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mem();
    pc_next = 8'h02;
    drive(2'd0, 8'h10, 8'h02, 1'b1, 8'hA5);
    chk_cnt++;
    if (alu_result !== 8'h12 || mem_rdata !== 8'h00)
      $display("FAIL store_cycle got addr=%h rdata=%h exp addr=12 rdata=00", alu_result, mem_rdata);
    else pass_cnt++;
    tick();
    drive(2'd0, 8'h10, 8'h02, 1'b0, 8'h00);
    chk_cnt++;
    if (mem_rdata !== 8'hA5) $display("FAIL load_a5 got=%h exp=a5", mem_rdata); else pass_cnt++;
    drive(2'd0, 8'h10, 8'h02, 1'b1, 8'h3C);
    tick();
    drive(2'd0, 8'h10, 8'h02, 1'b0, 8'h00);
    chk_cnt++;
    if (mem_rdata !== 8'h3C) $display("FAIL overwrite_3c got=%h exp=3c", mem_rdata); else pass_cnt++;
    drive(2'd0, 8'hFF, 8'h01, 1'b1, 8'h77);
    tick();
    drive(2'd3, 8'h00, 8'h00, 1'b0, 8'h00);
    chk_cnt++;
    if (mem_rdata !== 8'h77) $display("FAIL wrap_addr0 got=%h exp=77", mem_rdata); else pass_cnt++;
    chk_cnt++;
    if (pc !== 8'h02) $display("FAIL pc_hold got=%h exp=02", pc); else pass_cnt++;
  endtask

  task automatic test_midreset();
    rst_n = 0; pc_next = 8'h40;
    drive(2'd0, 8'h10, 8'h02, 1'b1, 8'hFF);
    tick();
    rst_n = 1;
    drive(2'd0, 8'h10, 8'h02, 1'b0, 8'h00);
    chk_cnt++;
    if (pc !== 8'h00) $display("FAIL midreset_pc got=%h exp=00", pc); else pass_cnt++;
    chk_cnt++;
    if (mem_rdata !== 8'h00) $display("FAIL midreset_mem12 got=%h exp=00", mem_rdata); else pass_cnt++;
    drive(2'd0, 8'hFF, 8'h01, 1'b0, 8'h00);
    chk_cnt++;
    if (mem_rdata !== 8'h00) $display("FAIL midreset_mem00 got=%h exp=00", mem_rdata); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [3:0] f;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      pc_next = 8'($urandom);
      drive(2'($urandom), 8'($urandom_range(0, 1) ? $urandom : $urandom_range(0, 15)),
            8'($urandom_range(0, 7)), 1'($urandom), 8'($urandom));
      model_alu(alu_ctrl, alu_a, alu_b, r, f);
      chk_cnt++;
      if (alu_result !== r || alu_flags !== f)
        $display("FAIL rand_alu[%0d] got=%h/%b exp=%h/%b", n, alu_result, alu_flags, r, f);
      else pass_cnt++;
      chk_cnt++;
      if (mem_rdata !== m_mem[r]) $display("FAIL rand_rdata[%0d] got=%h exp=%h", n, mem_rdata, m_mem[r]);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (pc !== m_pc) $display("FAIL rand_pc[%0d] got=%h exp=%h", n, pc, m_pc); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_mem();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
